// File: rtl/softcore_led_fader_if.sv
// Pin-level bundle between the LED PIO register and the fader: target pattern and mode
// in, PWM drive and busy flag out.
interface softcore_led_fader_if #(
  parameter int NUM_LEDS = 8
) ();
  logic [NUM_LEDS-1:0] led_in;
  logic                fade_en;
  logic [NUM_LEDS-1:0] led_out;
  logic                busy;

  modport master (output led_in, output fade_en, input led_out, input busy);
  modport slave  (input led_in, input fade_en, output led_out, output busy);
endinterface

// File: rtl/softcore_led_fader.sv
// Per-LED brightness ramp with PWM drive, fed from the LED PIO out_port bits.
// Define LED_FADER_GAMMA_EN for a squared (gamma-like) duty mapping; linear otherwise.
module softcore_led_fader #(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  softcore_led_fader_if.slave  bus
);

  localparam int                  PS_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PS_W-1:0]     PS_LAST = PS_W'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] MAX     = '1;
  localparam logic [PWM_BITS-1:0] ONE     = PWM_BITS'(1);

  logic [NUM_LEDS-1:0] led_q;
  logic [PS_W-1:0]     prescale;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] level     [NUM_LEDS];
  logic [PWM_BITS-1:0] level_nxt [NUM_LEDS];
  logic [PWM_BITS-1:0] target    [NUM_LEDS];
  logic [PWM_BITS-1:0] duty      [NUM_LEDS];
  logic [NUM_LEDS-1:0] out_nxt;
  logic [NUM_LEDS-1:0] mismatch;
  logic                step_tick;

`ifdef LED_FADER_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq [NUM_LEDS];
`endif

  assign step_tick = (prescale == PS_LAST);

  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      target[i]    = led_q[i] ? MAX : '0;
      level_nxt[i] = level[i];
      if (!bus.fade_en) begin
        level_nxt[i] = target[i];
      end else if (step_tick) begin
        // Saturating step toward the target; a flipped target simply reverses direction.
        if (led_q[i] && (level[i] != MAX)) begin
          level_nxt[i] = level[i] + ONE;
        end else if (!led_q[i] && (level[i] != '0)) begin
          level_nxt[i] = level[i] - ONE;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
`ifdef LED_FADER_GAMMA_EN
      sq[i]   = {{PWM_BITS{1'b0}}, level[i]} * {{PWM_BITS{1'b0}}, level[i]};
      duty[i] = sq[i][2*PWM_BITS-1:PWM_BITS];
`else
      duty[i] = level[i];
`endif
      // Full level forces constant on, since duty > pwm_cnt can never hold for pwm_cnt == MAX.
      out_nxt[i]  = (level[i] == MAX) || (duty[i] > pwm_cnt);
      mismatch[i] = (level[i] != target[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q       <= '0;
      prescale    <= '0;
      pwm_cnt     <= '0;
      bus.led_out <= '0;
      bus.busy    <= 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        level[i] <= '0;
      end
    end else begin
      led_q       <= bus.led_in;
      prescale    <= step_tick ? '0 : prescale + PS_W'(1);
      pwm_cnt     <= pwm_cnt + ONE;
      bus.led_out <= out_nxt;
      bus.busy    <= |mismatch;
      for (int i = 0; i < NUM_LEDS; i++) begin
        level[i] <= level_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_softcore_led_fader.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge monitor compares.
module tb_softcore_led_fader;

`ifdef LED_FADER_GAMMA_EN
  localparam bit GAMMA = 1'b1;
`else
  localparam bit GAMMA = 1'b0;
`endif
  localparam int TH = GAMMA ? 4 : 8;   // duty at level 8

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic reset_a, reset_b;
  softcore_led_fader_if #(.NUM_LEDS(8)) bus_a ();
  softcore_led_fader_if #(.NUM_LEDS(8)) bus_b ();

  softcore_led_fader #(.NUM_LEDS(8), .PWM_BITS(4), .STEP_DIV(2)) dut_a (
    .clk(clk), .reset(reset_a), .bus(bus_a)
  );
  softcore_led_fader #(.NUM_LEDS(8), .PWM_BITS(4), .STEP_DIV(64)) dut_b (
    .clk(clk), .reset(reset_b), .bus(bus_b)
  );

  typedef struct {
    int         cyc;
    logic [7:0] mask;
    logic [7:0] val;
    bit         cb;
    bit         bz;
    string      name;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   done_b = 1'b0;

  task automatic push(input bit sel, input int c, input logic [7:0] m, input logic [7:0] v,
                      input bit cb, input bit bz, input string n);
    exp_t e;
    e.cyc = c; e.mask = m; e.val = v; e.cb = cb; e.bz = bz; e.name = n;
    if (sel) qb.push_back(e);
    else     qa.push_back(e);
  endtask

  task automatic chk(input exp_t e, input logic [7:0] out, input logic bsy);
    n_chk++;
    if (e.cyc != cyc) begin
      $display("FAIL %s: due cycle %0d, checked at cycle %0d", e.name, e.cyc, cyc);
    end else if (((out & e.mask) !== (e.val & e.mask)) || (e.cb && (bsy !== e.bz))) begin
      $display("FAIL %s @%0d: led_out=%h busy=%b, required led_out=%h (mask %h) busy=%b%s",
               e.name, cyc, out, bsy, e.val, e.mask, e.bz, e.cb ? "" : " (busy unchecked)");
    end else begin
      n_pass++;
    end
  endtask

  always @(negedge clk) begin
    while (qa.size() > 0 && qa[0].cyc <= cyc) chk(qa.pop_front(), bus_a.led_out, bus_a.busy);
    while (qb.size() > 0 && qb[0].cyc <= cyc) chk(qb.pop_front(), bus_b.led_out, bus_b.busy);
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge: three reset edges, then release with the given inputs held.
  task automatic start(input logic [7:0] pat, input logic fe, output int r);
    int c0;
    c0 = cyc;
    reset_a = 1'b1;
    bus_a.led_in = pat;
    bus_a.fade_en = fe;
    for (int k = 1; k <= 3; k++) push(1'b0, c0 + k, 8'hFF, 8'h00, 1'b1, 1'b0, "reset");
    repeat (3) @(negedge clk);
    r = cyc;
    reset_a = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (qa.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (qa.size() > 0) begin
      n_chk++;
      $display("FAIL idle_timeout: %0d expectations pending, required 0", qa.size());
      qa.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // STEP_DIV=64 channel: PWM duty at level 8.
  initial begin
    int r;
    reset_b = 1'b1;
    bus_b.led_in = 8'h01;
    bus_b.fade_en = 1'b1;
    while (cyc < 3) @(negedge clk);
    reset_b = 1'b0;
    r = cyc;
    for (int t = 513; t <= 528; t++)
      push(1'b1, r + t, 8'h01, (((t - 1) % 16) < TH) ? 8'h01 : 8'h00, 1'b0, 1'b0, "duty_l8");
    push(1'b1, r + 529, 8'h00, 8'h00, 1'b1, 1'b1, "duty_busy");
    while (qb.size() > 0 && cyc < r + 700) @(negedge clk);
    done_b = 1'b1;
  end

  initial begin
    int r, r2, n;
    reset_a = 1'b1;
    bus_a.led_in = 8'hFF;
    bus_a.fade_en = 1'b1;
    @(negedge clk);

    // reset with all targets on, then release: every LED ramps
    start(8'hFF, 1'b1, r);
    push(1'b0, r + 1,  8'hFF, 8'h00, 1'b1, 1'b0, "rel_idle");
    push(1'b0, r + 2,  8'hFF, 8'h00, 1'b1, 1'b1, "rel_busy");
    push(1'b0, r + 17, 8'hFF, 8'hFF, 1'b1, 1'b1, "rel_ramp");
    wait_idle();

    // single-LED ramp up to saturation
    start(8'h01, 1'b1, r);
    push(1'b0, r + 1,  8'hFF, 8'h00, 1'b1, 1'b0, "up_t1");
    push(1'b0, r + 2,  8'hFF, 8'h00, 1'b1, 1'b1, "up_t2");
    push(1'b0, r + 5,  8'hFF, 8'h00, 1'b1, 1'b1, "up_t5");
    push(1'b0, r + 12, 8'hFF, 8'h00, 1'b1, 1'b1, "up_t12");
    push(1'b0, r + 17, 8'hFF, 8'h01, 1'b1, 1'b1, "up_t17");
    push(1'b0, r + 30, 8'h00, 8'h00, 1'b1, 1'b1, "up_busy14");
    for (int t = 31; t <= 36; t++) push(1'b0, r + t, 8'hFF, 8'h01, 1'b1, 1'b0, "up_full");
    wait_idle();

    // reversal at level 5, ramps down to 0 without wrapping
    start(8'h01, 1'b1, r);
    push(1'b0, r + 10, 8'h00, 8'h00, 1'b1, 1'b1, "rev_busy");
    push(1'b0, r + 17, 8'hFF, GAMMA ? 8'h00 : 8'h01, 1'b1, 1'b1, "rev_l2a");
    push(1'b0, r + 18, 8'hFF, GAMMA ? 8'h00 : 8'h01, 1'b1, 1'b1, "rev_l2b");
    push(1'b0, r + 19, 8'hFF, 8'h00, 1'b1, 1'b1, "rev_l1a");
    push(1'b0, r + 20, 8'hFF, 8'h00, 1'b1, 1'b1, "rev_l1b");
    for (int t = 21; t <= 40; t++) push(1'b0, r + t, 8'hFF, 8'h00, 1'b1, 1'b0, "rev_zero");
    wait_until(r + 10);
    bus_a.led_in = 8'h00;
    wait_idle();

    // fade_en 1->0 snaps to target; 0->1 resumes from the current level
    start(8'h01, 1'b1, r);
    push(1'b0, r + 11, 8'h00, 8'h00, 1'b1, 1'b1, "snap_busy");
    for (int t = 12; t <= 14; t++) push(1'b0, r + t, 8'hFF, 8'h01, 1'b1, 1'b0, "snap_full");
    push(1'b0, r + 17, 8'hFF, 8'h01, 1'b1, 1'b1, "resume");
    wait_until(r + 10);
    bus_a.fade_en = 1'b0;
    wait_until(r + 14);
    bus_a.fade_en = 1'b1;
    bus_a.led_in = 8'h00;
    wait_idle();

    // bypass mode and its two-edge latency
    start(8'hA5, 1'b0, r);
    push(1'b0, r + 1, 8'hFF, 8'h00, 1'b1, 1'b0, "byp_t1");
    push(1'b0, r + 2, 8'hFF, 8'h00, 1'b1, 1'b1, "byp_t2");
    for (int t = 3; t <= 11; t++) push(1'b0, r + t, 8'hFF, 8'hA5, 1'b1, 1'b0, "byp_a5");
    push(1'b0, r + 12, 8'hFF, 8'hA5, 1'b1, 1'b1, "byp_lat");
    for (int t = 13; t <= 16; t++) push(1'b0, r + t, 8'hFF, 8'h3C, 1'b1, 1'b0, "byp_3c");
    wait_until(r + 10);
    bus_a.led_in = 8'h3C;
    wait_idle();

    // reset at level 7, then the ramp restarts with the PWM phase from zero
    start(8'h01, 1'b1, r);
    push(1'b0, r + 14, 8'h00, 8'h00, 1'b1, 1'b1, "mid_busy");
    wait_until(r + 14);
    start(8'h01, 1'b1, r2);
    push(1'b0, r2 + 2,  8'hFF, 8'h00, 1'b1, 1'b1, "re_t2");
    push(1'b0, r2 + 12, 8'hFF, 8'h00, 1'b1, 1'b1, "re_t12");
    push(1'b0, r2 + 16, 8'hFF, 8'h00, 1'b1, 1'b1, "re_t16");
    push(1'b0, r2 + 17, 8'hFF, 8'h01, 1'b1, 1'b1, "re_t17");
    wait_idle();

    n = 0;
    while (!done_b && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!done_b) begin
      n_chk++;
      $display("FAIL duty_timeout: %0d expectations pending, required 0", qb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
